// File: rtl/bank_access_sequencer.sv
// Bank access sequencer: steps one SRAM bank through precharge, word-line,
// sense and response phases. Define BANK_ACCESS_SEQUENCER_BURST_EN for multi-beat bursts.
module bank_access_sequencer #(
    parameter int ROW_W   = 10,
    parameter int DATA_W  = 32,
    parameter int T_PRE   = 2,
    parameter int T_WL    = 2,
    parameter int T_SENSE = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ROW_W-1:0]  req_row,
    input  logic [DATA_W-1:0] req_wdata,
`ifdef BANK_ACCESS_SEQUENCER_BURST_EN
    input  logic [3:0]        req_len,
    output logic              rsp_last,
`endif
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_write,
    output logic [DATA_W-1:0] rsp_data,
    output logic [ROW_W-1:0]  wl_sel,
    output logic              wl_en,
    output logic              pre_en,
    output logic              wr_en,
    output logic [DATA_W-1:0] wr_data,
    output logic              sa_en,
    input  logic [DATA_W-1:0] sa_data
);

    typedef enum logic [2:0] {IDLE, PRE, WL, SENSE, RESP} state_t;

    localparam logic [3:0] PRE_LOAD   = 4'(T_PRE - 1);
    localparam logic [3:0] WL_LOAD    = 4'(T_WL - 1);
    localparam logic [3:0] SENSE_LOAD = 4'(T_SENSE - 1);

    state_t            state;
    logic [3:0]        phase_cnt;
    logic              lat_write;
    logic [DATA_W-1:0] lat_wdata;
`ifdef BANK_ACCESS_SEQUENCER_BURST_EN
    logic [3:0]        beats_left;
`endif

    // NOTE: every output is a flop written alongside the state transition that
    // implies it, so no input ever reaches an output combinationally; all of this
    // state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            phase_cnt <= '0;
            lat_write <= 1'b0;
            lat_wdata <= '0;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_write <= 1'b0;
            rsp_data  <= '0;
            wl_sel    <= '0;
            wl_en     <= 1'b0;
            pre_en    <= 1'b0;
            wr_en     <= 1'b0;
            wr_data   <= '0;
            sa_en     <= 1'b0;
`ifdef BANK_ACCESS_SEQUENCER_BURST_EN
            beats_left <= '0;
            rsp_last   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        state     <= PRE;
                        phase_cnt <= PRE_LOAD;
                        lat_write <= req_write;
                        lat_wdata <= req_wdata;
                        wl_sel    <= req_row;
                        req_ready <= 1'b0;
                        pre_en    <= 1'b1;
`ifdef BANK_ACCESS_SEQUENCER_BURST_EN
                        beats_left <= req_len;
`endif
                    end
                end
                PRE: begin
                    if (phase_cnt == 4'd0) begin
                        state     <= WL;
                        phase_cnt <= WL_LOAD;
                        pre_en    <= 1'b0;
                        wl_en     <= 1'b1;
                        wr_en     <= lat_write;
                        wr_data   <= lat_write ? lat_wdata : '0;
                    end else begin
                        phase_cnt <= phase_cnt - 4'd1;
                    end
                end
                WL: begin
                    if (phase_cnt == 4'd0) begin
                        wl_en   <= 1'b0;
                        wr_en   <= 1'b0;
                        wr_data <= '0;
                        if (lat_write) begin
                            state     <= RESP;
                            rsp_valid <= 1'b1;
                            rsp_write <= 1'b1;
`ifdef BANK_ACCESS_SEQUENCER_BURST_EN
                            rsp_last  <= (beats_left == 4'd0);
`endif
                        end else begin
                            state     <= SENSE;
                            phase_cnt <= SENSE_LOAD;
                            sa_en     <= 1'b1;
                        end
                    end else begin
                        phase_cnt <= phase_cnt - 4'd1;
                    end
                end
                SENSE: begin
                    if (phase_cnt == 4'd0) begin
                        state     <= RESP;
                        sa_en     <= 1'b0;
                        rsp_data  <= sa_data;
                        rsp_valid <= 1'b1;
                        rsp_write <= 1'b0;
`ifdef BANK_ACCESS_SEQUENCER_BURST_EN
                        rsp_last  <= (beats_left == 4'd0);
`endif
                    end else begin
                        phase_cnt <= phase_cnt - 4'd1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        rsp_write <= 1'b0;
`ifdef BANK_ACCESS_SEQUENCER_BURST_EN
                        rsp_last  <= 1'b0;
                        // Remaining beats chain straight into PRE on the next row.
                        if (beats_left != 4'd0) begin
                            beats_left <= beats_left - 4'd1;
                            wl_sel     <= wl_sel + 1'b1;
                            state      <= PRE;
                            phase_cnt  <= PRE_LOAD;
                            pre_en     <= 1'b1;
                        end else begin
                            state     <= IDLE;
                            req_ready <= 1'b1;
                        end
`else
                        state     <= IDLE;
                        req_ready <= 1'b1;
`endif
                    end
                end
                default: begin
                    state     <= IDLE;
                    req_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bank_access_sequencer.sv
// Directed self-checking bench for bank_access_sequencer (default parameters);
// the burst scenario is built only when BANK_ACCESS_SEQUENCER_BURST_EN is defined.
module tb_bank_access_sequencer;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [9:0]  req_row;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic        rsp_write;
    logic [31:0] rsp_data;
    logic [9:0]  wl_sel;
    logic        wl_en;
    logic        pre_en;
    logic        wr_en;
    logic [31:0] wr_data;
    logic        sa_en;
    logic [31:0] sa_data;
`ifdef BANK_ACCESS_SEQUENCER_BURST_EN
    logic [3:0]  req_len;
    logic        rsp_last;
`endif

    int checks;
    int errors;

    bank_access_sequencer dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_row   (req_row),
        .req_wdata (req_wdata),
`ifdef BANK_ACCESS_SEQUENCER_BURST_EN
        .req_len   (req_len),
        .rsp_last  (rsp_last),
`endif
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_write (rsp_write),
        .rsp_data  (rsp_data),
        .wl_sel    (wl_sel),
        .wl_en     (wl_en),
        .pre_en    (pre_en),
        .wr_en     (wr_en),
        .wr_data   (wr_data),
        .sa_en     (sa_en),
        .sa_data   (sa_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge, then settle 1 time unit before driving or sampling.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        checks++;
        if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready: got %b expected 1", req_ready); end
        checks++;
        if ({rsp_valid, rsp_write, wl_en, pre_en, wr_en, sa_en} !== 6'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got %b expected 000000", {rsp_valid, rsp_write, wl_en, pre_en, wr_en, sa_en});
        end
        checks++;
        if ({rsp_data, wr_data, wl_sel} !== 74'b0) begin
            errors++;
            $display("FAIL reset_data: got rsp_data=%h wr_data=%h wl_sel=%h expected all 0", rsp_data, wr_data, wl_sel);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_single_read();
        sa_data   = 32'hDEADBEEF;
        req_valid = 1'b1;
        req_write = 1'b0;
        req_row   = 10'h2A5;
        tick();
        req_valid = 1'b0;
        for (int k = 0; k <= 5; k++) begin
            checks++;
            if ({pre_en, wl_en, sa_en, wr_en, rsp_valid} !== {k < 2, k == 2 || k == 3, k == 4, 1'b0, k == 5}) begin
                errors++;
                $display("FAIL read_phase k=%0d: got pre/wl/sa/wr/rsp=%b expected %b", k,
                         {pre_en, wl_en, sa_en, wr_en, rsp_valid}, {k < 2, k == 2 || k == 3, k == 4, 1'b0, k == 5});
            end
            if (k < 4) begin
                checks++;
                if (wl_sel !== 10'h2A5) begin errors++; $display("FAIL read_wl_sel k=%0d: got %h expected 2a5", k, wl_sel); end
            end
            if (k < 5) tick();
        end
        checks++;
        if (rsp_data !== 32'hDEADBEEF || rsp_write !== 1'b0) begin
            errors++;
            $display("FAIL read_rsp: got data=%h write=%b expected deadbeef/0", rsp_data, rsp_write);
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        checks++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || rsp_data !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL read_handshake: got valid=%b ready=%b data=%h expected 0/1/deadbeef", rsp_valid, req_ready, rsp_data);
        end
    endtask

    task automatic test_write();
        sa_data   = 32'hCAFEF00D;
        req_valid = 1'b1;
        req_write = 1'b1;
        req_row   = 10'h007;
        req_wdata = 32'h12345678;
        tick();
        req_valid = 1'b0;
        req_wdata = 32'h0;
        for (int k = 0; k <= 4; k++) begin
            checks++;
            if ({pre_en, wl_en, wr_en, sa_en, rsp_valid} !== {k < 2, k == 2 || k == 3, k == 2 || k == 3, 1'b0, k == 4}) begin
                errors++;
                $display("FAIL write_phase k=%0d: got pre/wl/wr/sa/rsp=%b expected %b", k,
                         {pre_en, wl_en, wr_en, sa_en, rsp_valid}, {k < 2, k == 2 || k == 3, k == 2 || k == 3, 1'b0, k == 4});
            end
            checks++;
            if (wr_data !== ((k == 2 || k == 3) ? 32'h12345678 : 32'h0)) begin
                errors++;
                $display("FAIL write_wr_data k=%0d: got %h", k, wr_data);
            end
            if (k < 4) tick();
        end
        checks++;
        if (rsp_write !== 1'b1 || rsp_data !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL write_rsp: got write=%b data=%h expected 1/deadbeef", rsp_write, rsp_data);
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        sa_data   = 32'h0BADF00D;
        req_valid = 1'b1;
        req_write = 1'b0;
        req_row   = 10'h100;
        tick();
        req_valid = 1'b0;
        repeat (5) tick();
        // Stalled response; a pending new request and changing sa_data must not disturb it.
        sa_data   = 32'h11111111;
        req_valid = 1'b1;
        req_row   = 10'h155;
        for (int k = 0; k < 10; k++) begin
            checks++;
            if (rsp_valid !== 1'b1 || rsp_data !== 32'h0BADF00D || req_ready !== 1'b0) begin
                errors++;
                $display("FAIL stall k=%0d: got valid=%b data=%h ready=%b expected 1/0badf00d/0", k, rsp_valid, rsp_data, req_ready);
            end
            tick();
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        checks++;
        if (req_ready !== 1'b1 || pre_en !== 1'b0 || rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL stall_release: got ready=%b pre=%b valid=%b expected 1/0/0", req_ready, pre_en, rsp_valid);
        end
        tick();
        req_valid = 1'b0;
        checks++;
        if (pre_en !== 1'b1 || wl_sel !== 10'h155 || req_ready !== 1'b0) begin
            errors++;
            $display("FAIL stall_reaccept: got pre=%b wl_sel=%h ready=%b expected 1/155/0", pre_en, wl_sel, req_ready);
        end
        repeat (5) tick();
        checks++;
        if (rsp_valid !== 1'b1 || rsp_data !== 32'h11111111) begin
            errors++;
            $display("FAIL stall_second_rsp: got valid=%b data=%h expected 1/11111111", rsp_valid, rsp_data);
        end
        rsp_ready = 1'b1;
        tick();
    endtask

    task automatic test_back_to_back();
        // rsp_ready stays 1 throughout, including outside RESP where it is ignored.
        sa_data   = 32'hA5A5A5A5;
        rsp_ready = 1'b1;
        req_valid = 1'b1;
        req_write = 1'b0;
        req_row   = 10'h3C3;
        tick();
        for (int k = 0; k < 14; k++) begin
            checks++;
            if ({pre_en, rsp_valid, req_ready} !== {(k % 7) < 2, (k % 7) == 5, (k % 7) == 6}) begin
                errors++;
                $display("FAIL b2b k=%0d: got pre/rsp/ready=%b expected %b", k,
                         {pre_en, rsp_valid, req_ready}, {(k % 7) < 2, (k % 7) == 5, (k % 7) == 6});
            end
            if (k == 13) req_valid = 1'b0;
            tick();
        end
        checks++;
        if (req_ready !== 1'b1 || pre_en !== 1'b0 || rsp_data !== 32'hA5A5A5A5) begin
            errors++;
            $display("FAIL b2b_idle: got ready=%b pre=%b data=%h expected 1/0/a5a5a5a5", req_ready, pre_en, rsp_data);
        end
        rsp_ready = 1'b0;
    endtask

    task automatic test_abort();
        req_valid = 1'b1;
        req_write = 1'b1;
        req_row   = 10'h0F0;
        req_wdata = 32'h5A5A5A5A;
        tick();
        req_valid = 1'b0;
        repeat (2) tick();
        checks++;
        if (wl_en !== 1'b1 || wr_en !== 1'b1) begin
            errors++;
            $display("FAIL abort_first_wl: got wl=%b wr=%b expected 1/1", wl_en, wr_en);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if ({wl_en, pre_en, sa_en, wr_en, rsp_valid, req_ready} !== 6'b000001) begin
            errors++;
            $display("FAIL abort_outputs: got wl/pre/sa/wr/rsp/ready=%b expected 000001",
                     {wl_en, pre_en, sa_en, wr_en, rsp_valid, req_ready});
        end
        rsp_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            tick();
            checks++;
            if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || pre_en !== 1'b0) begin
                errors++;
                $display("FAIL abort_quiet k=%0d: got valid=%b ready=%b pre=%b expected 0/1/0", k, rsp_valid, req_ready, pre_en);
            end
        end
        rsp_ready = 1'b0;
    endtask

`ifdef BANK_ACCESS_SEQUENCER_BURST_EN
    task automatic test_burst();
        sa_data   = 32'h600DCAFE;
        rsp_ready = 1'b1;
        req_valid = 1'b1;
        req_write = 1'b0;
        req_row   = 10'h3FE;
        req_len   = 4'd2;
        tick();
        req_valid = 1'b0;
        req_len   = 4'd0;
        for (int k = 0; k <= 18; k++) begin
            checks++;
            if ({rsp_valid, rsp_last} !== {(k % 6) == 5 && k < 18, k == 17}) begin
                errors++;
                $display("FAIL burst_rsp k=%0d: got valid/last=%b expected %b", k,
                         {rsp_valid, rsp_last}, {(k % 6) == 5 && k < 18, k == 17});
            end
            if (k == 0 || k == 6 || k == 12) begin
                checks++;
                if (wl_sel !== ((k == 0) ? 10'h3FE : (k == 6) ? 10'h3FF : 10'h000) || pre_en !== 1'b1) begin
                    errors++;
                    $display("FAIL burst_row k=%0d: got wl_sel=%h pre=%b", k, wl_sel, pre_en);
                end
            end
            if (k < 18) tick();
        end
        checks++;
        if (req_ready !== 1'b1) begin errors++; $display("FAIL burst_done: got ready=%b expected 1", req_ready); end
        rsp_ready = 1'b0;
    endtask
`endif

    initial begin
        checks    = 0;
        errors    = 0;
        rst       = 1'b1;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_row   = '0;
        req_wdata = '0;
        rsp_ready = 1'b0;
        sa_data   = '0;
`ifdef BANK_ACCESS_SEQUENCER_BURST_EN
        req_len   = '0;
`endif
        test_reset();
        test_single_read();
        test_write();
        test_backpressure();
        test_back_to_back();
        test_abort();
`ifdef BANK_ACCESS_SEQUENCER_BURST_EN
        test_burst();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
